// File: rtl/kf76489_volume_writer.sv
// KF76489 volume command writer: maps a linear level to an attenuation code and writes the latch byte.
// Optional build macro KF76489_SKIP_REDUNDANT_EN suppresses writes that would not change a channel's attenuation.
module kf76489_volume_writer #(
  parameter int unsigned READY_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_channel,
  input  logic [5:0] req_level,
  output logic [7:0] data_bus_out,
  output logic       chip_enable_n,
  output logic       write_enable_n,
  input  logic       ready,
  output logic       busy,
  output logic [3:0] last_attenuation,
  output logic       timeout_error
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT_READY,
    RELEASE
  } state_t;

  // Nearest entry of the chip level table; ties go to the louder (smaller) code.
  function automatic logic [3:0] level_to_atten(input logic [5:0] level);
    logic [3:0] n;
    if (level >= 6'd57)      n = 4'd0;
    else if (level >= 6'd45) n = 4'd1;
    else if (level >= 6'd36) n = 4'd2;
    else if (level >= 6'd29) n = 4'd3;
    else if (level >= 6'd23) n = 4'd4;
    else if (level >= 6'd18) n = 4'd5;
    else if (level >= 6'd15) n = 4'd6;
    else if (level >= 6'd12) n = 4'd7;
    else if (level >= 6'd9)  n = 4'd8;
    else if (level >= 6'd7)  n = 4'd9;
    else if (level == 6'd6)  n = 4'd10;
    else if (level == 6'd5)  n = 4'd11;
    else if (level == 6'd4)  n = 4'd12;
    else if (level == 6'd3)  n = 4'd13;
    else if (level >= 6'd1)  n = 4'd14;
    else                     n = 4'd15;
    return n;
  endfunction

  state_t     state, state_next;
  logic [7:0] byte_q;
  logic [7:0] wait_cnt;
  logic [3:0] req_atten;
  logic       accept;
  logic       redundant;
  logic       timeout_hit;

`ifdef KF76489_SKIP_REDUNDANT_EN
  logic [3:0] shadow [4];
`endif

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = req_valid && req_ready;
  assign req_atten   = level_to_atten(req_level);
  assign timeout_hit = ({1'b0, wait_cnt} + 9'd1) >= 9'(READY_TIMEOUT);

`ifdef KF76489_SKIP_REDUNDANT_EN
  assign redundant = (req_atten == shadow[req_channel]);
`else
  assign redundant = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
    state_next     = state;
    chip_enable_n  = 1'b0;
    write_enable_n = 1'b1;
    data_bus_out   = byte_q;
    case (state)
      IDLE: begin
        chip_enable_n = 1'b1;
        data_bus_out  = 8'h00;
        if (accept && !redundant) state_next = SETUP;
      end
      SETUP:  state_next = STROBE;
      STROBE: begin
        write_enable_n = 1'b0;
        state_next     = WAIT_READY;
      end
      WAIT_READY: begin
        write_enable_n = 1'b0;
        if (ready || timeout_hit) state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: begin
        chip_enable_n = 1'b1;
        data_bus_out  = 8'h00;
        state_next    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state            <= IDLE;
      byte_q           <= 8'h00;
      last_attenuation <= 4'hF;
      timeout_error    <= 1'b0;
      wait_cnt         <= 8'd0;
`ifdef KF76489_SKIP_REDUNDANT_EN
      // NOTE: the shadow is reset because a redundant-write decision depends on its contents.
      for (int i = 0; i < 4; i++) shadow[i] <= 4'hF;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        byte_q           <= {1'b1, req_channel, 1'b1, req_atten};
        last_attenuation <= req_atten;
        timeout_error    <= 1'b0;
`ifdef KF76489_SKIP_REDUNDANT_EN
        shadow[req_channel] <= req_atten;
`endif
      end
      if (state == STROBE) wait_cnt <= 8'd0;
      else if (state == WAIT_READY) wait_cnt <= wait_cnt + 8'd1;
      if (state == WAIT_READY && !ready && timeout_hit) timeout_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kf76489_volume_writer.sv
// Directed self-checking bench for kf76489_volume_writer (default timeout instance plus a timeout=4 instance).
module tb_kf76489_volume_writer;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, ready, busy, chip_enable_n, write_enable_n, timeout_error;
  logic [1:0] req_channel;
  logic [5:0] req_level;
  logic [7:0] data_bus_out;
  logic [3:0] last_attenuation;

  logic       valid4, req_ready4, ready4, busy4, ce4, we4, timeout4;
  logic [1:0] ch4;
  logic [5:0] lvl4;
  logic [7:0] data4;
  logic [3:0] last4;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  kf76489_volume_writer dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_channel(req_channel), .req_level(req_level), .data_bus_out(data_bus_out),
    .chip_enable_n(chip_enable_n), .write_enable_n(write_enable_n), .ready(ready),
    .busy(busy), .last_attenuation(last_attenuation), .timeout_error(timeout_error)
  );

  kf76489_volume_writer #(.READY_TIMEOUT(4)) dut4 (
    .clock(clock), .reset(reset), .req_valid(valid4), .req_ready(req_ready4),
    .req_channel(ch4), .req_level(lvl4), .data_bus_out(data4),
    .chip_enable_n(ce4), .write_enable_n(we4), .ready(ready4),
    .busy(busy4), .last_attenuation(last4), .timeout_error(timeout4)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: nearest level-table entry, scanning from N=0 so ties keep the louder code.
  function automatic logic [3:0] exp_atten(input int level);
    int table_lvl [16] = '{63, 50, 40, 32, 25, 20, 16, 13, 10, 8, 6, 5, 4, 3, 2, 0};
    int best_d = 1000;
    logic [3:0] best = 4'd15;
    for (int n = 0; n < 16; n++) begin
      int d = (level > table_lvl[n]) ? level - table_lvl[n] : table_lvl[n] - level;
      if (d < best_d) begin
        best_d = d;
        best   = 4'(n);
      end
    end
    return best;
  endfunction

  // Issue one request on the main instance (which must be idle) and observe the bus cycle.
  task automatic run_write(input logic [1:0] ch, input logic [5:0] lvl,
                           output int ce_cnt, output int we_cnt, output int cycles,
                           output logic [7:0] cap);
    bit done = 0;
    ce_cnt = 0; we_cnt = 0; cycles = 0; cap = 8'h00;
    req_channel = ch;
    req_level   = lvl;
    req_valid   = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!chip_enable_n) begin
        ce_cnt++;
        cap = data_bus_out;
      end
      if (!write_enable_n) we_cnt++;
      if (!busy) begin
        cycles = i;
        done   = 1;
        break;
      end
      tick();
    end
    if (!done) check("write_completion_bound", 32'd0, 32'd1);
  endtask

  int         ce_cnt, we_cnt, cycles, lows;
  logic [7:0] cap;
  logic [3:0] n;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_channel = 2'd0; req_level = 6'd0; ready = 1'b1;
    valid4 = 1'b0; ch4 = 2'd0; lvl4 = 6'd0; ready4 = 1'b0;
    tick(); tick();
    reset = 1'b0;

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ce_n", 32'(chip_enable_n), 32'd1);
    check("rst_we_n", 32'(write_enable_n), 32'd1);
    check("rst_data", 32'(data_bus_out), 32'h00);
    check("rst_last_att", 32'(last_attenuation), 32'hF);
    check("rst_timeout", 32'(timeout_error), 32'd0);

    // Channel 0, level 63, READY high: cycle-by-cycle handshake.
    req_channel = 2'd0; req_level = 6'd63; req_valid = 1'b1;
    tick();  // E0 accept
    req_valid = 1'b0;
    check("e0_ce_n", 32'(chip_enable_n), 32'd0);
    check("e0_we_n", 32'(write_enable_n), 32'd1);
    check("e0_data", 32'(data_bus_out), 32'h90);
    check("e0_req_ready", 32'(req_ready), 32'd0);
    tick();  // E1
    check("e1_we_n", 32'(write_enable_n), 32'd0);
    tick();  // E2
    check("e2_we_n", 32'(write_enable_n), 32'd0);
    tick();  // E3 READY sampled
    check("e3_we_n", 32'(write_enable_n), 32'd1);
    check("e3_ce_n", 32'(chip_enable_n), 32'd0);
    check("e3_data_hold", 32'(data_bus_out), 32'h90);
    tick();  // E4
    check("e4_req_ready", 32'(req_ready), 32'd1);
    check("e4_ce_n", 32'(chip_enable_n), 32'd1);
    check("e4_data", 32'(data_bus_out), 32'h00);
    check("ch0_last_att", 32'(last_attenuation), 32'd0);

    run_write(2'd0, 6'd63, ce_cnt, we_cnt, cycles, cap);
`ifdef KF76489_SKIP_REDUNDANT_EN
    check("ch0_repeat_ce_cycles", 32'(ce_cnt), 32'd0);
`else
    check("ch0_ce_cycles", 32'(ce_cnt), 32'd4);
    check("ch0_we_cycles", 32'(we_cnt), 32'd2);
    check("ch0_idle_edges", 32'(cycles), 32'd4);
`endif

    // Sweep every level on channel 2.
    for (int lv = 0; lv < 64; lv++) begin
      n = exp_atten(lv);
      run_write(2'd2, 6'(lv), ce_cnt, we_cnt, cycles, cap);
      check($sformatf("sweep_last_att_%0d", lv), 32'(last_attenuation), 32'(n));
`ifdef KF76489_SKIP_REDUNDANT_EN
      if (ce_cnt != 0)
        check($sformatf("sweep_byte_%0d", lv), 32'(cap), 32'(8'hD0 | {4'h0, n}));
`else
      check($sformatf("sweep_byte_%0d", lv), 32'(cap), 32'(8'hD0 | {4'h0, n}));
`endif
    end
    run_write(2'd2, 6'd45, ce_cnt, we_cnt, cycles, cap);
    check("bound_45", 32'(last_attenuation), 32'd1);
    run_write(2'd2, 6'd44, ce_cnt, we_cnt, cycles, cap);
    check("bound_44", 32'(last_attenuation), 32'd2);
    run_write(2'd2, 6'd1, ce_cnt, we_cnt, cycles, cap);
    check("bound_1", 32'(last_attenuation), 32'd14);
    run_write(2'd2, 6'd0, ce_cnt, we_cnt, cycles, cap);
    check("bound_0", 32'(last_attenuation), 32'd15);

    // Channel 3, level 20, READY low for 10 cycles after WE_N falls.
    ready = 1'b0;
    req_channel = 2'd3; req_level = 6'd20; req_valid = 1'b1;
    tick();  // E0
    req_valid = 1'b0;
    check("slow_data", 32'(data_bus_out), 32'hF5);
    tick();  // E1: WE_N falls
    lows = 0;
    for (int i = 0; i < 11; i++) begin
      if (!write_enable_n) lows++;
      if (i < 10) tick();
    end
    check("slow_we_low", 32'(lows), 32'd11);
    ready = 1'b1;
    tick();
    check("slow_we_release", 32'(write_enable_n), 32'd1);
    check("slow_ce_hold", 32'(chip_enable_n), 32'd0);
    check("slow_data_hold", 32'(data_bus_out), 32'hF5);
    tick();
    check("slow_idle", 32'(busy), 32'd0);
    check("slow_timeout", 32'(timeout_error), 32'd0);

    // Timeout instance: READY stuck low.
    valid4 = 1'b1; ch4 = 2'd1; lvl4 = 6'd10;
    tick();
    valid4 = 1'b0;
    lows = 0;
    for (int i = 0; i < 50 && busy4; i++) begin
      if (!we4) lows++;
      tick();
    end
    check("to_we_low", 32'(lows), 32'd5);
    check("to_idle", 32'(busy4), 32'd0);
    check("to_flag", 32'(timeout4), 32'd1);
    tick(); tick();
    check("to_flag_sticky", 32'(timeout4), 32'd1);
    ready4 = 1'b1; valid4 = 1'b1; lvl4 = 6'd30;
    tick();
    valid4 = 1'b0;
    check("to_flag_cleared", 32'(timeout4), 32'd0);
    check("to_next_data", 32'(data4), 32'hB3);
    for (int i = 0; i < 20 && busy4; i++) tick();
    check("to_next_idle", 32'(busy4), 32'd0);

    // Two identical level-40 requests on channel 1.
    run_write(2'd1, 6'd40, ce_cnt, we_cnt, cycles, cap);
    check("dup1_byte", 32'(cap), 32'hB2);
    check("dup1_ce_cycles", 32'(ce_cnt), 32'd4);
    run_write(2'd1, 6'd40, ce_cnt, we_cnt, cycles, cap);
`ifdef KF76489_SKIP_REDUNDANT_EN
    check("dup2_ce_cycles", 32'(ce_cnt), 32'd0);
    check("dup2_req_ready", 32'(req_ready), 32'd1);
`else
    check("dup2_ce_cycles", 32'(ce_cnt), 32'd4);
    check("dup2_byte", 32'(cap), 32'hB2);
`endif
    check("dup2_last_att", 32'(last_attenuation), 32'd2);

    // Reset during WAIT_READY.
    ready = 1'b0;
    req_channel = 2'd0; req_level = 6'd25; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_we_n", 32'(write_enable_n), 32'd0);
    reset = 1'b1;
    tick();
    check("mid_rst_ce_n", 32'(chip_enable_n), 32'd1);
    check("mid_rst_we_n", 32'(write_enable_n), 32'd1);
    check("mid_rst_data", 32'(data_bus_out), 32'h00);
    check("mid_rst_last_att", 32'(last_attenuation), 32'hF);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
